// File: rtl/inst_fetch_buffer_if.sv
// rtl/inst_fetch_buffer_if.sv - instruction-memory read port and decode handshake bundle
interface inst_fetch_buffer_if #(
    parameter int INST_ADDR_WIDTH = 9,
    parameter int INST_WIDTH      = 32
);
    logic [INST_ADDR_WIDTH-1:0] imem_addr;
    logic                       imem_rd_en;
    logic [INST_WIDTH-1:0]      imem_rdata;
    logic                       inst_valid;
    logic                       inst_ready;
    logic [INST_WIDTH-1:0]      inst_data;
    logic [INST_ADDR_WIDTH-1:0] inst_pc;

    modport master (
        output imem_addr,
        output imem_rd_en,
        input  imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc
    );

    modport slave (
        input  imem_addr,
        input  imem_rd_en,
        output imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - credit-gated fetch issue into a decode FIFO; FETCH_BUF_PC_TAG_EN adds per-entry PC tags
module inst_fetch_buffer #(
    parameter int INST_ADDR_WIDTH = 9,
    parameter int INST_WIDTH      = 32,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       flush,
    input  logic [INST_ADDR_WIDTH-1:0] pc_in,
    output logic                       pc_en,
    output logic [$clog2(DEPTH):0]     occupancy,
    inst_fetch_buffer_if.master        bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W:0]   DEPTH_CREDIT = (OCC_W+1)'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE      = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic                  inflight;
    logic [INST_WIDTH-1:0] data_mem [DEPTH];

    logic [OCC_W:0] credit;
    logic           issue;
    logic           push;
    logic           pop;

    // Issue only when every buffered and in-flight word still has a slot; a pop this cycle is not credited.
    // Issue is also held off while reset is asserted so the incrementor never advances during reset.
    always_comb begin
        credit = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
        issue  = reset && run && !flush && (credit < DEPTH_CREDIT);
        push   = inflight && !flush;
        pop    = (occ != '0) && bus.inst_ready;
    end

    assign bus.imem_rd_en = issue;
    assign pc_en          = issue;
    assign bus.imem_addr  = pc_in;
    assign bus.inst_valid = (occ != '0);
    assign bus.inst_data  = data_mem[rd_ptr];
    assign occupancy      = occ;

    // FIFO pointers, occupancy and in-flight flag; flush discards everything and outranks push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (push) begin
                data_mem[wr_ptr] <= bus.imem_rdata;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                occ <= occ + OCC_ONE;
            end else if (pop && !push) begin
                occ <= occ - OCC_ONE;
            end
        end
    end

`ifdef FETCH_BUF_PC_TAG_EN
    logic [INST_ADDR_WIDTH-1:0] inflight_pc;
    logic [INST_ADDR_WIDTH-1:0] pc_mem [DEPTH];

    // Remember the address of the outstanding read and file it alongside its returned word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_pc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i] <= '0;
            end
        end else begin
            if (issue) begin
                inflight_pc <= pc_in;
            end
            if (push) begin
                pc_mem[wr_ptr] <= inflight_pc;
            end
        end
    end

    assign bus.inst_pc = pc_mem[rd_ptr];
`else
    assign bus.inst_pc = '0;
`endif
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb/tb_inst_fetch_buffer.sv - randomized scoreboard bench for inst_fetch_buffer
module tb_inst_fetch_buffer;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] pc_in;
    logic [AW-1:0] redirect = '0;
    logic          pc_en;
    logic [2:0]    occupancy;

    int checks = 0;
    int errors = 0;

    inst_fetch_buffer_if #(.INST_ADDR_WIDTH(AW), .INST_WIDTH(DW)) bus ();

    inst_fetch_buffer #(.INST_ADDR_WIDTH(AW), .INST_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .flush     (flush),
        .pc_in     (pc_in),
        .pc_en     (pc_en),
        .occupancy (occupancy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // PC incrementor and synchronous instruction memory holding 0x1000+addr
    always @(posedge clk) begin
        if (!reset) pc_in <= '0;
        else if (flush) pc_in <= redirect;
        else if (pc_en) pc_in <= pc_in + 1'b1;
        bus.imem_rdata <= bus.imem_rd_en ? (32'h1000 + 32'(bus.imem_addr)) : $urandom;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every issued fetch not yet popped, in order, with its issue cycle
    typedef struct {
        logic [AW-1:0] addr;
        int unsigned   cyc;
    } fetch_t;

    fetch_t      exp_q[$];
    int unsigned cyc = 0;
    bit          prev_reset_low = 1'b0;

    always @(negedge clk) begin
        int     landed;
        logic   exp_rd;
        fetch_t f;
        logic [AW-1:0] exp_pc;
        landed = 0;
        foreach (exp_q[i]) if (exp_q[i].cyc + 2 <= cyc) landed++;
        chk("occupancy", 64'(occupancy), 64'(landed));
        chk("inst_valid", 64'(bus.inst_valid), 64'(landed != 0));
        chk("no_overflow", 64'(occupancy <= 3'(DEPTH)), 64'd1);
        if (prev_reset_low) begin
            chk("reset_inst_data", 64'(bus.inst_data), 64'd0);
            chk("reset_inst_pc", 64'(bus.inst_pc), 64'd0);
        end
        if (reset) begin
            exp_rd = run && !flush && (exp_q.size() < DEPTH);
            chk("imem_rd_en", 64'(bus.imem_rd_en), 64'(exp_rd));
            chk("pc_en", 64'(pc_en), 64'(exp_rd));
            if (bus.imem_rd_en) chk("imem_addr", 64'(bus.imem_addr), 64'(pc_in));
        end
        if (!reset || flush) begin
            exp_q.delete();
        end else begin
            if (bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 64'(bus.inst_valid), 64'd0);
                end else begin
                    f = exp_q.pop_front();
`ifdef FETCH_BUF_PC_TAG_EN
                    exp_pc = f.addr;
`else
                    exp_pc = '0;
`endif
                    chk("inst_data", 64'(bus.inst_data), 64'(32'h1000 + 32'(f.addr)));
                    chk("inst_pc", 64'(bus.inst_pc), 64'(exp_pc));
                end
            end
            if (bus.imem_rd_en) exp_q.push_back('{addr: pc_in, cyc: cyc});
        end
        prev_reset_low = !reset;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_occ(input int target);
        int k;
        for (k = 0; k < 50 && occupancy != 3'(target); k++) step();
        if (k == 50) begin
            checks++;
            errors++;
            $display("FAIL wait_occupancy actual=%0d expected=%0d", occupancy, target);
        end
    endtask

    initial begin
        bus.inst_ready = 1'b0;
        repeat (3) step();

        // reset release, continuous stream
        reset = 1'b1;
        run = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (20) step();

        // back-pressure until full, then drain
        bus.inst_ready = 1'b0;
        repeat (10) step();
        chk("full_occupancy", 64'(occupancy), 64'(DEPTH));
        bus.inst_ready = 1'b1;
        repeat (10) step();

        // simultaneous push/pop at occupancy 2
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.inst_ready = 1'b0;
        wait_occ(2);
        bus.inst_ready = 1'b1;
        repeat (8) step();

        // flush the cycle after an issue
        begin
            int k;
            for (k = 0; k < 50 && !bus.imem_rd_en; k++) step();
            if (k == 50) begin
                checks++;
                errors++;
                $display("FAIL wait_issue actual=0 expected=1");
            end
        end
        step();
        flush = 1'b1;
        redirect = 9'h0a0;
        step();
        flush = 1'b0;
        repeat (10) step();

        // pointer wrap with random decode acceptance
        for (int i = 0; i < 40; i++) begin
            bus.inst_ready = 1'($urandom_range(0, 1));
            step();
        end

        // fully randomized traffic
        for (int i = 0; i < 400; i++) begin
            run = ($urandom_range(0, 9) < 8);
            bus.inst_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 29) == 0);
            reset = !($urandom_range(0, 99) == 0);
            redirect = AW'($urandom);
            step();
        end
        reset = 1'b1;
        flush = 1'b0;

        // reset mid-stream at occupancy 3 with a read in flight
        flush = 1'b1;
        step();
        flush = 1'b0;
        run = 1'b1;
        bus.inst_ready = 1'b0;
        wait_occ(3);
        reset = 1'b0;
        run = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("post_reset_pc_en", 64'(pc_en), 64'd0);
        chk("post_reset_occupancy", 64'(occupancy), 64'd0);
        run = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (20) step();

        run = 1'b0;
        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Consumer end of the program-counter path. It takes the current PC from the PC incrementor and issues reads to the synchronous instruction memory. It drives the incrementor's advance enable so the PC only moves when a fetch is actually issued. Returned instructions are buffered in a small FIFO and presented to decode over a valid/ready handshake.

## Interface
Parameters:
- INST_ADDR_WIDTH, 9: PC / instruction-memory address width.
- INST_WIDTH, 32: instruction word width.
- DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; asserted when 0, sampled on rising clk.
- run  in  1  fetch permitted while 1.
- flush  in  1  discard buffered and in-flight instructions.
- pc_in  in  INST_ADDR_WIDTH  current PC from the incrementor.
- pc_en  out  1  advance enable to the incrementor.
- imem_addr  out  INST_ADDR_WIDTH  read address; equals pc_in.
- imem_rd_en  out  1  read strobe.
- imem_rdata  in  INST_WIDTH  read data, valid exactly 1 cycle after imem_rd_en.
- inst_valid  out  1  FIFO head holds an instruction.
- inst_ready  in  1  decode accepts the head.
- inst_data  out  INST_WIDTH  head instruction.
- inst_pc  out  INST_ADDR_WIDTH  address of the head instruction.
- occupancy  out  $clog2(DEPTH)+1  entries held.

## Operation
- **Issue condition:** run && !flush && (occupancy + inflight < DEPTH).
  - The condition uses registered values only; a same-cycle pop is not counted.
  - imem_rd_en is the issue condition, combinational. pc_en = imem_rd_en.
  - The PC advances on the same edge the read is issued.
- **In-flight tracking:** on issue, register inflight=1 and inflight_pc=pc_in. Otherwise inflight=0.
- **Response:** in the cycle after issue (inflight=1, no flush), push {imem_rdata, inflight_pc} at wr_ptr.
- **Pop:** occurs when inst_valid && inst_ready; rd_ptr increments.
- **Occupancy update:** push only → +1; pop only → −1; both or neither → unchanged.
- **Pointers:** log2(DEPTH) bits, wrap modulo DEPTH.
- **Full:** occupancy==DEPTH. The credit rule makes it impossible to push when full. Overflow is a design error, and the bench asserts on it.
- **Head outputs:** inst_valid = (occupancy != 0). inst_data and inst_pc show the head entry combinationally, and are don't-care when inst_valid=0.
- **flush=1 (single cycle):**
  - pointers and occupancy cleared;
  - any response arriving this cycle is dropped;
  - inflight cleared;
  - no issue this cycle.
  - flush has priority over push and pop.
  - PC redirection is outside this block.
- **run=0:** stops new issues. An in-flight response still lands, and buffered entries still drain.
- **Reset (reset=0):**
  - occupancy=0, pointers=0, inflight=0;
  - storage cleared to 0, so inst_data=0 and inst_pc=0;
  - inst_valid=0, pc_en=0, imem_rd_en=0.
  - Reset mid-operation drops everything with no partial push.

## Timing
- Read issued in cycle N; entry written at the edge ending N+1; inst_valid=1 from cycle N+2.
- Fetch-to-decode latency is 2 cycles, with no bypass.
- Sustained throughput is 1 instruction/cycle while decode holds inst_ready=1 and DEPTH≥4.
- Occupancy changes on the edge after the push/pop cycle.
- pc_en and imem_rd_en are combinational from registered state plus run/flush. There is no path from inst_ready.

## Configuration
- FETCH_BUF_PC_TAG_EN defined:
  - inflight_pc register and per-entry PC storage are built;
  - inst_pc carries each instruction's fetch address.
- Not defined:
  - PC storage is omitted;
  - inst_pc is tied to 0;
  - all other behaviour is identical.

## Test plan
- **Reset then stream:** release reset, run=1, inst_ready=1, pc_in counting from 0 with memory word = 0x1000+addr.
  - inst_valid first high 2 cycles after the first imem_rd_en.
  - Data sequence 0x1000, 0x1001, …; inst_pc 0, 1, … (with macro).
- **Back-pressure to full:** DEPTH=4, inst_ready=0.
  - Exactly 4 reads issued; pc_en then 0; occupancy=4; pc_in frozen.
  - Raise inst_ready: 4 pops, then issue resumes.
- **Simultaneous push/pop at occupancy 2:** occupancy stays 2 and FIFO order is preserved.
- **Flush with read in flight:** flush in cycle N+1 after an issue in cycle N.
  - occupancy=0 next cycle; dropped word never appears on inst_data; no imem_rd_en during the flush cycle.
- **Pointer wrap:** push/pop 10 entries with DEPTH=4 and random inst_ready; output order matches issue order.
- **Reset mid-stream:** reset=0 for 1 cycle at occupancy 3 with a read in flight.
  - Next cycle: inst_valid=0, occupancy=0, pc_en=0; no stale entry after reset is released.
